// File: rtl/apb_master.sv
// APB master: turns single-beat commands from a valid/ready request port into
// APB3 SETUP/ACCESS transfers and returns a one-cycle completion pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS wait on
// PREADY to TIMEOUT_CYCLES cycles (error completion on expiry). In the default
// build the timeout logic is absent and ACCESS waits on PREADY indefinitely.
module apb_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // command request port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // completion port
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB requester signals
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The expiring wait cycle is the one seen with the counter at TIMEOUT_CYCLES-1,
    // i.e. the edge on which the count would reach TIMEOUT_CYCLES.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;
`endif

    // Transfer sequencer: all APB and completion outputs are registered here.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end

                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end

                ACCESS: begin
                    if (PREADY) begin
                        // cmd_ready returns with rsp_valid so the next command
                        // can be taken on the following edge (3-cycle minimum).
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        if (!PWRITE) begin
                            rsp_rdata <= PRDATA;
                        end
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == TMO_LAST) begin
                        state     <= IDLE;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    state     <= IDLE;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: reset, directed table, back-to-back
// traffic, randomized transfers against a transaction-level model with a
// memory-backed completer, wait/timeout behaviour and reset mid-transfer.
module tb_apb_master;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int TMO = 16;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    apb_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    // Reference state: completer memory, last completion data, last bus address.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] last_addr;

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned waits;
        bit          serr;
        logic [DW-1:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic junk_cmd();
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
    endtask

    // One complete transfer, entered and left at a negedge with the DUT idle.
    // The completer inserts 'waits' PREADY-low ACCESS cycles.
    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int unsigned waits, input bit serr,
                           output logic [DW-1:0] rd, output bit er);
        bit            to;
        int unsigned   nacc;
        bit            last;
        logic [DW-1:0] prd;
        logic [DW-1:0] exp_rd;
        bit            exp_er;
        to   = TO_EN && (waits >= TMO);
        nacc = to ? TMO : waits + 1;
        prd  = mem[a];

        chk("entry_idle", {PSEL, PENABLE, cmd_ready}, {1'b0, 1'b0, 1'b1});
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        PREADY    = 1'($urandom);
        PSLVERR   = 1'($urandom);
        PRDATA    = DW'($urandom);

        @(negedge PCLK);
        chk("setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid},
            {1'b1, 1'b0, wr, a, d, 1'b0, 1'b0});
        // Requests while busy must be ignored.
        cmd_valid = 1'b1;
        junk_cmd();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);

        for (int unsigned k = 0; k < nacc; k++) begin
            @(negedge PCLK);
            chk("access", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready, rsp_valid},
                {1'b1, 1'b1, wr, a, d, 1'b0, 1'b0});
            last    = (k == nacc - 1);
            junk_cmd();
            PREADY  = last && !to;
            PSLVERR = last ? serr : 1'($urandom);
            PRDATA  = (last && !wr) ? prd : DW'($urandom);
        end

        @(negedge PCLK);
        exp_er = to ? 1'b1 : serr;
        exp_rd = to ? '0 : (wr ? last_rdata : prd);
        chk("complete", {PSEL, PENABLE, cmd_ready, rsp_valid, PADDR},
            {1'b0, 1'b0, 1'b1, 1'b1, a});
        chk("rsp_err", rsp_err, exp_er);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        rd = rsp_rdata;
        er = rsp_err;

        last_rdata = exp_rd;
        last_addr  = a;
        if (wr && !serr && !to) mem[a] = d;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            junk_cmd();
            PREADY = 1'($urandom);
            @(negedge PCLK);
            chk("idle", {PSEL, PENABLE, cmd_ready, rsp_valid, PADDR},
                {1'b0, 1'b0, 1'b1, 1'b0, last_addr});
        end
        PREADY = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        bit            er;
        int unsigned   hi;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10'h3FF] = 32'h0BADF00D;
        last_rdata = '0;
        last_addr  = '0;

        tbl[0] = '{1'b1, 10'h001, 32'hDEADBEEF, 0, 1'b0, 32'h00000000, 1'b0};
        tbl[1] = '{1'b1, 10'h006, 32'hDEADBEF4, 1, 1'b0, 32'h00000000, 1'b0};
        tbl[2] = '{1'b0, 10'h006, 32'h00000000, 2, 1'b0, 32'hDEADBEF4, 1'b0};
        tbl[3] = '{1'b0, 10'h001, 32'h11111111, 0, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[4] = '{1'b0, 10'h3FF, 32'h00000000, 0, 1'b1, 32'h0BADF00D, 1'b1};
        tbl[5] = '{1'b1, 10'h3FF, 32'h12345678, 0, 1'b1, 32'h0BADF00D, 1'b1};
        tbl[6] = '{1'b0, 10'h3FF, 32'h00000000, 3, 1'b0, 32'h0BADF00D, 1'b0};
        tbl[7] = '{1'b1, 10'h200, 32'hA5A5A5A5, 0, 1'b0, 32'h0BADF00D, 1'b0};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state, including cmd_ready low until the first edge after release.
        @(negedge PCLK);
        @(negedge PCLK);
        chk("reset_ctrl", {PSEL, PENABLE, PWRITE, PADDR, cmd_ready, rsp_valid, rsp_err}, '0);
        chk("reset_pwdata", PWDATA, '0);
        chk("reset_rdata", rsp_rdata, '0);
        PRESETn = 1'b1;
        #1;
        chk("ready_before_edge", cmd_ready, 1'b0);
        @(negedge PCLK);
        chk("ready_after_release", cmd_ready, 1'b1);

        // Directed table, issued back to back.
        for (int i = 0; i < 8; i++) begin
            do_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].serr, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
        end
        idle_cycles(2);

        // Back-to-back writes then reads; each transfer exactly 3 cycles.
        for (int i = 0; i < 6; i++)
            do_xfer(1'b1, AW'(i + 1), 32'hDEADBEEF + DW'(i), 0, 1'b0, rd, er);
        for (int i = 0; i < 6; i++) begin
            do_xfer(1'b0, AW'(i + 1), '0, 0, 1'b0, rd, er);
            chk($sformatf("b2b_rd%0d", i), rd, 32'hDEADBEEF + DW'(i));
        end
        idle_cycles(1);

        // Randomized transfers with random waits, errors and idle gaps.
        for (int n = 0; n < 60; n++) begin
            do_xfer(1'($urandom), AW'($urandom), DW'($urandom),
                    $urandom_range(0, 4), ($urandom_range(0, 7) == 0), rd, er);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end

`ifdef APB_MASTER_TIMEOUT_EN
        // Longest wait that still completes normally, then expiry.
        do_xfer(1'b0, 10'h123, '0, TMO - 1, 1'b0, rd, er);
        chk("tmo_boundary_err", er, 1'b0);
        do_xfer(1'b0, 10'h124, '0, 500, 1'b0, rd, er);
        chk("tmo_err", er, 1'b1);
        chk("tmo_rdata", rd, '0);
        do_xfer(1'b1, 10'h125, 32'hCAFEF00D, 500, 1'b0, rd, er);
        chk("tmo_wr_err", er, 1'b1);
        idle_cycles(1);
`else
        // Without the timeout, a stalled ACCESS is held indefinitely.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 10'h010;
        PREADY    = 1'b0;
        @(negedge PCLK);
        chk("nt_setup", {PSEL, PENABLE}, 2'b10);
        hi = 0;
        for (int i = 0; i < 105; i++) begin
            junk_cmd();
            @(negedge PCLK);
            if (PSEL && PENABLE && !rsp_valid) hi++;
        end
        chk("no_timeout_held", hi, 105);
        cmd_valid = 1'b0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h13572468;
        @(negedge PCLK);
        chk("nt_rsp", {rsp_valid, rsp_err, PSEL, PADDR}, {1'b1, 1'b0, 1'b0, 10'h010});
        chk("nt_rdata", rsp_rdata, 32'h13572468);
        last_rdata = 32'h13572468;
        last_addr  = 10'h010;
        PREADY     = 1'b0;
        idle_cycles(1);
`endif

        // Reset during an ACCESS wait state abandons the transfer.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 10'h055;
        PREADY    = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_pre", {PSEL, PENABLE}, 2'b11);
        #1;
        PRESETn = 1'b0;
        #1;
        chk("rst_async", {PSEL, PENABLE, cmd_ready, rsp_valid, PADDR}, '0);
        PREADY = 1'b1;
        @(negedge PCLK);
        chk("rst_held", {PSEL, rsp_valid, cmd_ready}, 3'b000);
        PRESETn = 1'b1;
        PREADY  = 1'b0;
        @(negedge PCLK);
        chk("rst_recover", {PSEL, PENABLE, cmd_ready, rsp_valid}, 4'b0010);
        last_rdata = '0;
        last_addr  = '0;
        do_xfer(1'b0, 10'h3FF, '0, 1, 1'b0, rd, er);
        chk("post_rst_rd", rd, 32'h0BADF00D);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the PWDATA, PRDATA, cmd_wdata and rsp_rdata width.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the PADDR and cmd_addr width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the access-phase wait limit (used only under REQ-027).
REQ-004 PCLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 PRESETn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  SHALL indicate a command request.
REQ-007 cmd_ready  output  1  SHALL indicate that a command is accepted this cycle.
REQ-008 cmd_write  input  1  SHALL select the command type: 1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_WIDTH  SHALL carry the command address.
REQ-010 cmd_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-011 rsp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_WIDTH  SHALL carry the read data.
REQ-013 rsp_err  output  1  SHALL report a completion error.
REQ-014 PSEL, PENABLE, PWRITE  output  1 each  SHALL be the APB select, enable and direction signals.
REQ-015 PADDR  output  ADDR_WIDTH and PWDATA  output  DATA_WIDTH  SHALL be the APB address and write data.
REQ-016 PRDATA  input  DATA_WIDTH, PREADY  input  1 and PSLVERR  input  1  SHALL be the completer response signals.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on the edge where cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance, the FSM SHALL move IDLE->SETUP and register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA.
REQ-020 In SETUP the outputs SHALL be PSEL=1 and PENABLE=0, and the FSM SHALL move unconditionally to ACCESS on the next edge.
REQ-021 In ACCESS the outputs SHALL be PSEL=1 and PENABLE=1, held for as long as PREADY=0, with no limit unless REQ-027 applies.
REQ-022 PADDR, PWRITE and PWDATA SHALL stay constant from SETUP through the end of ACCESS, and SHALL keep their last values in IDLE.
REQ-023 On the edge where the FSM is in ACCESS and PREADY=1, the block SHALL:
  - move to IDLE with PSEL=0 and PENABLE=0;
  - assert rsp_valid for exactly one cycle;
  - set rsp_err=PSLVERR;
  - for reads, set rsp_rdata=PRDATA; for writes, leave rsp_rdata unchanged.
REQ-024 Latency SHALL be as follows, with acceptance at edge N and zero wait states:
  - PSEL rises after edge N;
  - PENABLE rises after edge N+1;
  - rsp_valid is high in the cycle after edge N+2.
  Each wait cycle SHALL add one cycle to this latency.
REQ-025 A new command SHALL be acceptable in the same cycle that rsp_valid is high, giving a minimum of 3 cycles per transfer.
REQ-026 cmd_valid SHALL be ignored in SETUP and ACCESS; no command is lost, because cmd_ready=0 there.

Configuration
REQ-027 With APB_MASTER_TIMEOUT_EN defined, a wait counter SHALL count ACCESS cycles with PREADY=0. When it reaches TIMEOUT_CYCLES, the block SHALL:
  - go to IDLE and drop PSEL and PENABLE;
  - pulse rsp_valid with rsp_err=1 and rsp_rdata=0;
  - clear the counter.
  The counter SHALL also clear on every entry to SETUP.
REQ-028 Without APB_MASTER_TIMEOUT_EN, no counter logic SHALL exist, ACCESS SHALL wait on PREADY indefinitely, and TIMEOUT_CYCLES SHALL be unused.

Reset
REQ-029 While PRESETn=0, the block SHALL asynchronously force:
  - the FSM to IDLE;
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0;
  - the wait counter to 0.
  cmd_ready SHALL be 0 while in reset and 1 from the first edge after release.
REQ-030 A reset asserted during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse.

Verification
REQ-031 Write with zero waits: cmd write addr=0x001 data=0xDEADBEEF, PREADY=1 -> PSEL 2 cycles, PENABLE 1 cycle, PADDR=0x001, PWDATA=0xDEADBEEF stable, rsp_valid 1 cycle, rsp_err=0.
REQ-032 Read with 2 wait states: cmd read addr=0x006, PREADY low for 2 ACCESS cycles, PRDATA=0xDEADBEF4 -> PENABLE high 3 cycles, rsp_rdata=0xDEADBEF4, rsp_valid at acceptance+5.
REQ-033 Back-to-back: 6 writes (addr 0x001-0x006, data 0xDEADBEEF+i) then 6 reads with cmd_valid held -> each transfer takes 3 cycles, and read data matches the written data.
REQ-034 Error: PSLVERR=1 with PREADY=1 on a read of 0x3FF -> rsp_err=1 and rsp_valid pulse.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held 0 -> after 16 ACCESS cycles, PSEL=0, rsp_err=1, rsp_rdata=0; without the macro, PSEL stays 1 for more than 100 cycles.
REQ-036 Reset mid-ACCESS: PRESETn=0 for 1 cycle during a wait state -> PSEL=0 immediately, no rsp_valid, cmd_ready=1 after release.
